ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Multi-cycle RV32M multiply/divide unit for the execute stage; a parametrised successor to the single-cycle ALU/compare path. It accepts one operation per start handshake, computes it iteratively, and holds EX with `stall_req` until the result is ready. It sits beside the ALU in `instruction_execute`, fed with the already-forwarded `alu_input_1`/`alu_input_2`. Its result is muxed into `alu_o` ahead of the EX/MEM register.

## Interface
- `XLEN`, default 32: operand/result width; must be even and at least 8.
- `MUL_BITS`, default 4: multiplier bits retired per cycle; must divide `XLEN`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: **asynchronous, active-low** reset (fixed).
- `start` in 1: EX holds an M-extension op (`ctrl_word_in.opcode == op_reg`, funct7 = 0000001).
- `op` in 3: funct3, typed `muldiv_op_t`.
- `a` in `XLEN`: rs1 operand, post-forwarding.
- `b` in `XLEN`: rs2 operand, post-forwarding.
- `flush` in 1: kill any in-flight op (branch taken upstream).
- `ma_stall` in 1: MEM stalled; hold a finished result.
- `busy` out 1: FSM is in MUL or DIV.
- `done` out 1: `result` is valid.
- `result` out `XLEN`: final value.
- `stall_req` out 1: freeze IF/ID/EX.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- **IDLE**
  - On `start`, latch `a`, `b` and `op`.
  - mul/mulh/mulhsu/mulhu go to MUL; div/divu/rem/remu go to DIV.
  - Special cases go directly to DONE:
    - Divide by zero: quotient = all ones; remainder = `a`.
    - Signed overflow (`a` = 2^(XLEN-1), `b` = -1): quotient = `a`; remainder = 0.
- **MUL**
  - Signed operands are sign-corrected to magnitudes.
  - Shift-add, `MUL_BITS` per cycle, into a 2·`XLEN` accumulator.
  - Runs for `XLEN/MUL_BITS` cycles, then applies the sign fix.
  - mul returns the low `XLEN` bits; the mulh variants return the high `XLEN` bits.
- **DIV**
  - Restoring radix-2, 1 bit per cycle, for `XLEN` cycles, on magnitudes.
  - Quotient sign = sign(`a`) xor sign(`b`); remainder sign = sign(`a`).
- **DONE**
  - `done` = 1 and `result` is stable.
  - `start` is ignored (the same instruction is still in EX).
  - Go to IDLE on the first edge with `ma_stall` = 0.
- `stall_req` = (IDLE and `start`) or MUL or DIV. It is 0 in DONE and while `rst` is low.
- `flush` (synchronous) from any state: next state IDLE, `done` 0, `result` keeps its last value. `flush` has priority over `start`.
- Async reset from any state: IDLE, `busy` 0, `done` 0, `result` 0, all internal registers 0.

## Timing
- Cycle 0: IDLE with `start`; `stall_req` = 1 combinationally; operands latched at the edge.
- MUL latency: state MUL for cycles 1..`XLEN/MUL_BITS`, then DONE. Defaults give MUL in cycles 1–8 and DONE in cycle 9.
- DIV latency: state DIV for cycles 1..`XLEN`, then DONE. Default gives DONE in cycle 33.
- Special cases: DONE in cycle 1.
- `stall_req` is high from cycle 0 through the last MUL/DIV cycle. EX advances at the end of the first DONE cycle in which `ma_stall` = 0.
- Back-to-back ops: the new `start` is seen in IDLE the cycle after DONE exits, so there is no bubble beyond that cycle.
- `ma_stall` during MUL/DIV: no effect, iteration continues.
- `ma_stall` in DONE: stay in DONE; `result` and `done` are held.
- `flush` in the same cycle as DONE exit: next state is IDLE either way.

## Structure
- Package `muldiv_types`:
  - `muldiv_op_t` enum {mul=0, mulh=1, mulhsu=2, mulhu=3, div=4, divu=5, rem=6, remu=7}.
  - `muldiv_state_t` enum.
  - Constant funct7 `7'b0000001`.
- Sub-module `radix2_divider`: handles the DIV iteration, has `XLEN` as a parameter, and exposes `load`/`step`/`quotient`/`remainder`. The FSM and multiplier live in the top module.

## Test plan
- mulhsu, `a` = 0xFFFFFFFF (-1), `b` = 0xFFFFFFFF (unsigned) -> result 0xFFFFFFFF. `done` goes high in cycle 9. `stall_req` is high in cycles 0–8.
- div, `a` = -7, `b` = 2 -> 0xFFFFFFFD. rem, same operands -> 0xFFFFFFFF. Both reach DONE in cycle 33.
- divu, `b` = 0 -> 0xFFFFFFFF in cycle 1. rem, `a` = 0x80000000, `b` = -1 -> 0. div, same operands -> 0x80000000.
- mul 6×7 with `ma_stall` = 1 for 3 cycles after DONE -> `result` 42 held and `done` high for 4 cycles. Then IDLE, and the next `start` is accepted.
- Mid-operation events:
  - `flush` in DIV cycle 10 -> IDLE next cycle, `stall_req` 0, no `done`.
  - `rst` low in MUL cycle 3 -> `busy`/`done`/`result` 0 immediately, without waiting for a clock edge.
- `XLEN` = 16, `MUL_BITS` = 2: mulhu 0xFFFF×0xFFFF -> 0xFFFE, with DONE in cycle 9.

Source files
------------

// File: rtl/muldiv_types_pkg.sv
// rtl/muldiv_types_pkg.sv - shared types and constants for the RV32M multiply/divide unit
package muldiv_types;

    typedef enum logic [2:0] {
        mul    = 3'd0,
        mulh   = 3'd1,
        mulhsu = 3'd2,
        mulhu  = 3'd3,
        div    = 3'd4,
        divu   = 3'd5,
        rem    = 3'd6,
        remu   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/radix2_divider.sv
// rtl/radix2_divider.sv - restoring radix-2 unsigned divider, one quotient bit per step
module radix2_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] dvs_r;
    logic [XLEN:0]   trial;

    // Outputs show the value after the pending step, so the caller can capture
    // the final result on the same edge as the last step.
    always_comb begin
        trial = {rem_r, quo_r[XLEN-1]} - {1'b0, dvs_r};
        if (!trial[XLEN]) begin
            remainder = trial[XLEN-1:0];
            quotient  = {quo_r[XLEN-2:0], 1'b1};
        end else begin
            remainder = {rem_r[XLEN-2:0], quo_r[XLEN-1]};
            quotient  = {quo_r[XLEN-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_r <= '0;
            quo_r <= '0;
            dvs_r <= '0;
        end else if (load) begin
            rem_r <= '0;
            quo_r <= dividend;
            dvs_r <= divisor;
        end else if (step) begin
            rem_r <= remainder;
            quo_r <= quotient;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide unit that stalls EX until done
module ex_muldiv_unit
    import muldiv_types::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  muldiv_op_t      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    input  logic            ma_stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            stall_req
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / MUL_BITS - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);

    muldiv_state_t     state;
    muldiv_op_t        op_r;
    logic              q_neg;
    logic              r_neg;
    logic [XLEN-1:0]   mcand;
    logic [2*XLEN-1:0] prod;
    logic [CW-1:0]     cnt;

    logic              a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf;

    always_comb begin
        a_sgn    = (op inside {mul, mulh, mulhsu, div, rem});
        b_sgn    = (op inside {mul, mulh, div, rem});
        a_neg    = a_sgn & a[XLEN-1];
        b_neg    = b_sgn & b[XLEN-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        div_zero = op[2] && (b == '0);
        div_ovf  = (op == div || op == rem) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    end

    // Shift-add: the multiplier sits in the low half of prod and is consumed
    // MUL_BITS at a time while partial sums accumulate into the high half.
    logic [XLEN+MUL_BITS-1:0] pp, psum;
    logic [2*XLEN-1:0]        prod_next, prod_fix;

    always_comb begin
        pp        = {{MUL_BITS{1'b0}}, mcand} * {{XLEN{1'b0}}, prod[MUL_BITS-1:0]};
        psum      = {{MUL_BITS{1'b0}}, prod[2*XLEN-1:XLEN]} + pp;
        prod_next = {psum, prod[XLEN-1:MUL_BITS]};
        prod_fix  = q_neg ? -prod_next : prod_next;
    end

    logic            div_load, div_step;
    logic [XLEN-1:0] quo, rmd, quo_fix, rmd_fix;

    assign div_load = (state == IDLE) && start && !flush && op[2] && !div_zero && !div_ovf;
    assign div_step = (state == DIV) && !flush;
    assign quo_fix  = q_neg ? -quo : quo;
    assign rmd_fix  = r_neg ? -rmd : rmd;

    radix2_divider #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load),
        .step      (div_step),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quo),
        .remainder (rmd)
    );

    assign stall_req = rst && (((state == IDLE) && start) || (state == MUL) || (state == DIV));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            op_r   <= mul;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            mcand  <= '0;
            prod   <= '0;
            cnt    <= '0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    op_r  <= op;
                    cnt   <= '0;
                    q_neg <= a_neg ^ b_neg;
                    r_neg <= a_neg;
                    if (div_zero) begin
                        result <= (op == div || op == divu) ? '1 : a;
                        state  <= DONE;
                        done   <= 1'b1;
                    end else if (div_ovf) begin
                        result <= (op == div) ? a : '0;
                        state  <= DONE;
                        done   <= 1'b1;
                    end else if (op[2]) begin
                        state <= DIV;
                        busy  <= 1'b1;
                    end else begin
                        mcand <= a_mag;
                        prod  <= {{XLEN{1'b0}}, b_mag};
                        state <= MUL;
                        busy  <= 1'b1;
                    end
                end
                MUL: begin
                    prod <= prod_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == MUL_LAST) begin
                        result <= (op_r == mul) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                DIV: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == DIV_LAST) begin
                        result <= op_r[1] ? rmd_fix : quo_fix;
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                DONE: if (!ma_stall) begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - scoreboard bench for ex_muldiv_unit with directed vectors
module tb_ex_muldiv_unit;
    import muldiv_types::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, flush, ma_stall;
    muldiv_op_t  op;
    logic [31:0] a, b, result;
    logic        busy, done, stall_req;

    logic        start16;
    muldiv_op_t  op16;
    logic [15:0] a16, b16, result16;
    logic        busy16, done16, stall16;

    ex_muldiv_unit #(.XLEN(32), .MUL_BITS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .ma_stall(ma_stall), .busy(busy), .done(done),
        .result(result), .stall_req(stall_req)
    );

    ex_muldiv_unit #(.XLEN(16), .MUL_BITS(2)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16),
        .flush(flush), .ma_stall(ma_stall), .busy(busy16), .done(done16),
        .result(result16), .stall_req(stall16)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [15:0] exp16_q[$];
    logic [31:0] mon_e;
    logic [15:0] mon16_e;
    logic        done_q = 1'b0;
    logic        done16_q = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (done && !done_q) begin
            if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
                mon_e = exp_q.pop_front();
                chk("result", result, mon_e);
            end
        end
        done_q = done;
    end

    always @(negedge clk) begin
        if (done16 && !done16_q) begin
            if (exp16_q.size() == 0) chk("unexpected_done16", 32'd1, 32'd0);
            else begin
                mon16_e = exp16_q.pop_front();
                chk("result16", {16'd0, result16}, {16'd0, mon16_e});
            end
        end
        done16_q = done16;
    end

    // Returns at the negedge of the first done cycle; n = cycle index of that cycle.
    task automatic wait_done(input int lat);
        int n;
        n = 0;
        for (int c = 1; c <= lat + 5; c++) begin
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            if (done) begin
                n = c;
                break;
            end
            chk("stall_busy", {31'd0, stall_req}, 32'd1);
        end
        chk("latency", n, lat);
        chk("stall_done", {31'd0, stall_req}, 32'd0);
    endtask

    task automatic run_op(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] e, input int lat);
        @(posedge clk);
        #1;
        start = 1'b1; op = o; a = x; b = y;
        exp_q.push_back(e);
        @(negedge clk);
        chk("stall_c0", {31'd0, stall_req}, 32'd1);
        wait_done(lat);
    endtask

    initial begin
        logic [31:0] prev;
        int n16;
        rst = 1'b0; start = 1'b0; op = mul; a = '0; b = '0;
        flush = 1'b0; ma_stall = 1'b0;
        start16 = 1'b0; op16 = mul; a16 = '0; b16 = '0;

        repeat (2) @(negedge clk);
        start = 1'b1;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        run_op(mulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9);
        run_op(div,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        run_op(rem,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        run_op(divu,   32'd1234,      32'd0,         32'hFFFF_FFFF, 1);
        run_op(rem,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        run_op(div,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op(rem,    32'd55,        32'd0,         32'd55,        1);
        run_op(mul,    32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 9);
        run_op(mulh,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 9);
        run_op(mulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 9);
        run_op(divu,   32'd100,       32'd7,         32'd14,        33);
        run_op(remu,   32'd100,       32'd7,         32'd2,         33);
        run_op(div,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op(rem,    32'd7,         32'hFFFF_FFFE, 32'd1,         33);

        // mul held in DONE by ma_stall for three extra cycles
        @(posedge clk);
        #1;
        start = 1'b1; op = mul; a = 32'd6; b = 32'd7; ma_stall = 1'b1;
        exp_q.push_back(32'd42);
        wait_done(9);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            chk("hold_done", {31'd0, done}, 32'd1);
            chk("hold_result", result, 32'd42);
            if (k == 3) ma_stall = 1'b0;
        end
        @(negedge clk);
        chk("after_hold_done", {31'd0, done}, 32'd0);
        chk("after_hold_busy", {31'd0, busy}, 32'd0);
        run_op(mulhu, 32'd6, 32'd7, 32'd0, 9);
        run_op(mul,   32'd6, 32'd7, 32'd42, 9);

        // flush in DIV cycle 10
        prev = 32'd42;
        @(posedge clk);
        #1;
        start = 1'b1; op = div; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("flush_pre_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_stall", {31'd0, stall_req}, 32'd0);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_done", {31'd0, done}, 32'd0);
        chk("flush_result", result, prev);
        repeat (40) @(negedge clk);
        chk("flush_no_done", {31'd0, done}, 32'd0);

        // async reset in MUL cycle 3
        @(posedge clk);
        #1;
        start = 1'b1; op = mul; a = 32'd3; b = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rstmid_pre_busy", {31'd0, busy}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_done", {31'd0, done}, 32'd0);
        chk("rstmid_result", result, 32'd0);
        chk("rstmid_stall", {31'd0, stall_req}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_op(mul, 32'd3, 32'd5, 32'd15, 9);

        // 16-bit instance, two multiplier bits per cycle
        @(posedge clk);
        #1;
        start16 = 1'b1; op16 = mulhu; a16 = 16'hFFFF; b16 = 16'hFFFF;
        exp16_q.push_back(16'hFFFE);
        n16 = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1 start16 = 1'b0;
            @(negedge clk);
            if (done16) begin
                n16 = c;
                break;
            end
        end
        chk("latency16", n16, 9);

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size() + exp16_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
